// File: rtl/jhash_stream_if.sv
// Stream-producer bus for jhash_stream: message input, core group
// stream, core result and result handshake.
interface jhash_stream_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_empty;
  logic             in_ready;
  logic [31:0]      stream_data0;
  logic [31:0]      stream_data1;
  logic [31:0]      stream_data2;
  logic             stream_valid;
  logic             stream_done;
  logic [1:0]       stream_left;
  logic             stream_ack;
  logic [31:0]      hash_out;
  logic             hash_done;
  logic [31:0]      result;
  logic             result_valid;
  logic             result_ready;
  logic             core_clr;
  logic [CNT_W-1:0] msg_words;

  modport master (
    input  in_data,
    input  in_valid,
    input  in_last,
    input  in_empty,
    output in_ready,
    output stream_data0,
    output stream_data1,
    output stream_data2,
    output stream_valid,
    output stream_done,
    output stream_left,
    input  stream_ack,
    input  hash_out,
    input  hash_done,
    output result,
    output result_valid,
    input  result_ready,
    output core_clr,
    output msg_words
  );

  modport slave (
    output in_data,
    output in_valid,
    output in_last,
    output in_empty,
    input  in_ready,
    input  stream_data0,
    input  stream_data1,
    input  stream_data2,
    input  stream_valid,
    input  stream_done,
    input  stream_left,
    output stream_ack,
    output hash_out,
    output hash_done,
    input  result,
    input  result_valid,
    output result_ready,
    input  core_clr,
    input  msg_words
  );
endinterface

// File: rtl/jhash_stream.sv
// Producer end of the jhash_core stream: packs message words into
// 3-word groups, hands off the final group, returns the hash.
module jhash_stream #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  jhash_stream_if.master bus
);

  typedef enum logic [2:0] {
    S_FILL,
    S_SEND,
    S_FINAL,
    S_RESULT,
    S_CLR
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [31:0]      c_q;
  logic [1:0]       idx_q;
  logic [1:0]       left_q;
  logic [31:0]      result_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept;
  logic take_word;
  logic end_msg;
  logic ack_take;
  logic clr_grp;
  logic hash_take;

  assign accept    = (state_q == S_FILL) & bus.in_valid;
  assign take_word = accept & ~bus.in_empty;
  assign end_msg   = accept & bus.in_last;
  assign ack_take  = (state_q == S_SEND) & bus.stream_ack;
  assign hash_take = (state_q == S_FINAL) & bus.hash_done;
  assign clr_grp   = ack_take | (state_q == S_CLR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // A last beat always wins over a full group: length 3n ends in S_FINAL
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FILL: begin
        if (end_msg) begin
          state_d = S_FINAL;
        end else if (take_word && idx_q == 2'd2) begin
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.stream_ack) begin
          state_d = S_FILL;
        end
      end
      S_FINAL: begin
        if (bus.hash_done) begin
          state_d = S_RESULT;
        end
      end
      S_RESULT: begin
        if (bus.result_ready) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      idx_q <= '0;
    end else if (clr_grp) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      idx_q <= '0;
    end else if (take_word) begin
      case (idx_q)
        2'd0:    a_q <= bus.in_data;
        2'd1:    b_q <= bus.in_data;
        default: c_q <= bus.in_data;
      endcase
      idx_q <= idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_q <= '0;
    end else if (end_msg) begin
      left_q <= bus.in_empty ? idx_q : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state_q == S_CLR) begin
      cnt_q <= '0;
    end else if (take_word && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else if (hash_take) begin
      result_q <= bus.hash_out;
    end
  end

  // Handshake outputs are pure state decodes, no path from stream_ack
  always_comb begin
    bus.in_ready     = 1'b0;
    bus.stream_valid = 1'b0;
    bus.stream_done  = 1'b0;
    bus.stream_left  = 2'd0;
    bus.result_valid = 1'b0;
    bus.core_clr     = 1'b0;
    unique case (state_q)
      S_FILL: begin
        bus.in_ready = 1'b1;
      end
      S_SEND: begin
        bus.stream_valid = 1'b1;
      end
      S_FINAL: begin
        bus.stream_valid = 1'b1;
        bus.stream_done  = 1'b1;
        bus.stream_left  = left_q;
      end
      S_RESULT: begin
        bus.result_valid = 1'b1;
      end
      S_CLR: begin
        bus.core_clr = 1'b1;
      end
      default: begin
        bus.in_ready = 1'b0;
      end
    endcase
  end

  assign bus.stream_data0 = a_q;
  assign bus.stream_data1 = b_q;
  assign bus.stream_data2 = c_q;
  assign bus.result       = result_q;
  assign bus.msg_words    = cnt_q;

endmodule
